// File: rtl/hacd_pkg.sv
// Shared HACD definitions: AXI read widths, port-tag position, AR payload and AR FSM state types.
`ifndef HACD_AXI4_ID_WIDTH
`define HACD_AXI4_ID_WIDTH 4
`endif
`ifndef HACD_MC_AXI4_ID_WIDTH
`define HACD_MC_AXI4_ID_WIDTH 6
`endif

package hacd_pkg;

    localparam int unsigned HACD_AXI4_ID_W        = `HACD_AXI4_ID_WIDTH;
    localparam int unsigned HACD_AXI4_ADDR_W      = 32;
    localparam int unsigned HACD_AXI4_DATA_W      = 64;
    localparam int unsigned HACD_AXI4_LEN_W       = 8;
    localparam int unsigned HACD_AXI4_SIZE_W      = 3;
    localparam int unsigned HACD_AXI4_BURST_W     = 2;
    localparam int unsigned HACD_AXI4_USER_W      = 4;

    localparam int unsigned HACD_MC_AXI4_ID_W     = `HACD_MC_AXI4_ID_WIDTH;
    localparam int unsigned HACD_MC_AXI4_ADDR_W   = 32;
    localparam int unsigned HACD_MC_AXI4_DATA_W   = 64;
    localparam int unsigned HACD_MC_AXI4_LEN_W    = 8;
    localparam int unsigned HACD_MC_AXI4_SIZE_W   = 3;
    localparam int unsigned HACD_MC_AXI4_BURST_W  = 2;
    localparam int unsigned HACD_MC_AXI4_USER_W   = 4;

    localparam int unsigned HACD_RD_PORTS         = 2;
    // MC id bit carrying the issuing port; requester ids sit below it
    localparam int unsigned HACD_PORT_TAG_BIT     = HACD_AXI4_ID_W;

    typedef struct packed {
        logic [HACD_MC_AXI4_ID_W-1:0]    id;
        logic [HACD_MC_AXI4_ADDR_W-1:0]  addr;
        logic [HACD_MC_AXI4_LEN_W-1:0]   len;
        logic [HACD_MC_AXI4_SIZE_W-1:0]  size;
        logic [HACD_MC_AXI4_BURST_W-1:0] burst;
        logic                            lock;
        logic [3:0]                      cache;
        logic [2:0]                      prot;
        logic [3:0]                      qos;
        logic [3:0]                      region;
        logic [HACD_MC_AXI4_USER_W-1:0]  user;
    } ar_payload_t;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_HOLD = 1'b1
    } ar_state_e;

endpackage

// File: rtl/HACD_AXI_RD_BUS.sv
// HACD requester-side AXI4 read bus (AR and R channels).
interface HACD_AXI_RD_BUS;
    import hacd_pkg::*;

    logic                          axi_arvalid;
    logic                          axi_arready;
    logic [HACD_AXI4_ID_W-1:0]     axi_arid;
    logic [HACD_AXI4_ADDR_W-1:0]   axi_araddr;
    logic [HACD_AXI4_LEN_W-1:0]    axi_arlen;
    logic [HACD_AXI4_SIZE_W-1:0]   axi_arsize;
    logic [HACD_AXI4_BURST_W-1:0]  axi_arburst;
    logic                          axi_arlock;
    logic [3:0]                    axi_arcache;
    logic [2:0]                    axi_arprot;
    logic [3:0]                    axi_arqos;
    logic [3:0]                    axi_arregion;
    logic [HACD_AXI4_USER_W-1:0]   axi_aruser;

    logic                          axi_rvalid;
    logic                          axi_rready;
    logic [HACD_AXI4_ID_W-1:0]     axi_rid;
    logic [HACD_AXI4_DATA_W-1:0]   axi_rdata;
    logic [1:0]                    axi_rresp;
    logic                          axi_rlast;
    logic [HACD_AXI4_USER_W-1:0]   axi_ruser;

    modport mstr (
        output axi_arvalid, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
               axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arregion, axi_aruser,
               axi_rready,
        input  axi_arready, axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_ruser
    );

    modport slv (
        input  axi_arvalid, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
               axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arregion, axi_aruser,
               axi_rready,
        output axi_arready, axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_ruser
    );

endinterface

// File: rtl/HACD_MC_AXI_RD_BUS.sv
// Memory-controller-side AXI4 read bus (AR and R channels), wider id carries the port tag.
interface HACD_MC_AXI_RD_BUS;
    import hacd_pkg::*;

    logic                             axi_arvalid;
    logic                             axi_arready;
    logic [HACD_MC_AXI4_ID_W-1:0]     axi_arid;
    logic [HACD_MC_AXI4_ADDR_W-1:0]   axi_araddr;
    logic [HACD_MC_AXI4_LEN_W-1:0]    axi_arlen;
    logic [HACD_MC_AXI4_SIZE_W-1:0]   axi_arsize;
    logic [HACD_MC_AXI4_BURST_W-1:0]  axi_arburst;
    logic                             axi_arlock;
    logic [3:0]                       axi_arcache;
    logic [2:0]                       axi_arprot;
    logic [3:0]                       axi_arqos;
    logic [3:0]                       axi_arregion;
    logic [HACD_MC_AXI4_USER_W-1:0]   axi_aruser;

    logic                             axi_rvalid;
    logic                             axi_rready;
    logic [HACD_MC_AXI4_ID_W-1:0]     axi_rid;
    logic [HACD_MC_AXI4_DATA_W-1:0]   axi_rdata;
    logic [1:0]                       axi_rresp;
    logic                             axi_rlast;
    logic [HACD_MC_AXI4_USER_W-1:0]   axi_ruser;

    modport mstr (
        output axi_arvalid, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
               axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arregion, axi_aruser,
               axi_rready,
        input  axi_arready, axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_ruser
    );

    modport slv (
        input  axi_arvalid, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
               axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arregion, axi_aruser,
               axi_rready,
        output axi_arready, axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_ruser
    );

endinterface

// File: rtl/hacd_rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant, pointer flips only after a contested grant.
module hacd_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (advance && (req == 2'b11)) begin
            ptr_q <= ~ptr_q;
        end
    end

endmodule

// File: rtl/hacd_mc_rd_arbiter.sv
// Shares the MC read bus between the host path (s0) and the HACD engine (s1):
// round-robin AR with one held AR stage, per-port outstanding limit, id-tagged R routing.
module hacd_mc_rd_arbiter
    import hacd_pkg::*;
#(
    parameter  int unsigned MAX_OUTSTANDING = 8,
    localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    HACD_AXI_RD_BUS.slv             s0,
    HACD_AXI_RD_BUS.slv             s1,
    HACD_MC_AXI_RD_BUS.mstr         m,
    output logic                    busy
);

    if (HACD_MC_AXI4_ID_W < HACD_AXI4_ID_W + 1) begin : g_bad_id_w
        $error("MC id width must hold requester id plus port tag");
    end
    if (HACD_MC_AXI4_DATA_W != HACD_AXI4_DATA_W) begin : g_bad_data_w
        $error("data width mismatch between HACD and MC buses");
    end
    if (HACD_MC_AXI4_LEN_W != HACD_AXI4_LEN_W) begin : g_bad_len_w
        $error("len width mismatch between HACD and MC buses");
    end
    if (HACD_MC_AXI4_SIZE_W != HACD_AXI4_SIZE_W) begin : g_bad_size_w
        $error("size width mismatch between HACD and MC buses");
    end
    if (HACD_MC_AXI4_BURST_W != HACD_AXI4_BURST_W) begin : g_bad_burst_w
        $error("burst width mismatch between HACD and MC buses");
    end
    if (MAX_OUTSTANDING < 1) begin : g_bad_max_out
        $error("MAX_OUTSTANDING must be at least 1");
    end

    ar_state_e         state_q, state_d;
    ar_payload_t       ar_q, ar_d;
    ar_payload_t       req_pl [HACD_RD_PORTS];
    logic [CNT_W-1:0]  cnt_q  [HACD_RD_PORTS];

    logic [1:0] arvalid_c;
    logic [1:0] req_c;
    logic [1:0] gnt_c;
    logic [1:0] rdone_c;
    logic       tag_c;
    logic       r_hs_c;
    logic       unused_rid_c;

    // Requester payloads with the port tag stitched into the MC id
    always_comb begin
        req_pl[0] = '{id:     HACD_MC_AXI4_ID_W'({1'b0, s0.axi_arid}),
                      addr:   s0.axi_araddr,   len:    s0.axi_arlen,
                      size:   s0.axi_arsize,   burst:  s0.axi_arburst,
                      lock:   s0.axi_arlock,   cache:  s0.axi_arcache,
                      prot:   s0.axi_arprot,   qos:    s0.axi_arqos,
                      region: s0.axi_arregion, user:   s0.axi_aruser};
        req_pl[1] = '{id:     HACD_MC_AXI4_ID_W'({1'b1, s1.axi_arid}),
                      addr:   s1.axi_araddr,   len:    s1.axi_arlen,
                      size:   s1.axi_arsize,   burst:  s1.axi_arburst,
                      lock:   s1.axi_arlock,   cache:  s1.axi_arcache,
                      prot:   s1.axi_arprot,   qos:    s1.axi_arqos,
                      region: s1.axi_arregion, user:   s1.axi_aruser};
    end

    assign arvalid_c = {s1.axi_arvalid, s0.axi_arvalid};

    // Only idle, out-of-reset and under-limit requests compete
    always_comb begin
        req_c = 2'b00;
        for (int i = 0; i < int'(HACD_RD_PORTS); i++) begin
            req_c[i] = rst_n && (state_q == AR_IDLE) && arvalid_c[i] &&
                       (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    hacd_rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_c),
        .advance (|gnt_c),
        .gnt     (gnt_c)
    );

    assign s0.axi_arready = gnt_c[0];
    assign s1.axi_arready = gnt_c[1];

    always_comb begin
        state_d = state_q;
        ar_d    = ar_q;
        case (state_q)
            AR_IDLE: begin
                if (|gnt_c) begin
                    state_d = AR_HOLD;
                    ar_d    = gnt_c[1] ? req_pl[1] : req_pl[0];
                end
            end
            AR_HOLD: begin
                if (m.axi_arready) begin
                    state_d = AR_IDLE;
                end
            end
            default: state_d = AR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= AR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_q <= '0;
        end else begin
            ar_q <= ar_d;
        end
    end

    assign m.axi_arvalid  = (state_q == AR_HOLD);
    assign m.axi_arid     = ar_q.id;
    assign m.axi_araddr   = ar_q.addr;
    assign m.axi_arlen    = ar_q.len;
    assign m.axi_arsize   = ar_q.size;
    assign m.axi_arburst  = ar_q.burst;
    assign m.axi_arlock   = ar_q.lock;
    assign m.axi_arcache  = ar_q.cache;
    assign m.axi_arprot   = ar_q.prot;
    assign m.axi_arqos    = ar_q.qos;
    assign m.axi_arregion = ar_q.region;
    assign m.axi_aruser   = ar_q.user;

    // R beats steered by the tag bit; payload fans out to both ports
    assign tag_c        = m.axi_rid[HACD_PORT_TAG_BIT];
    assign unused_rid_c = ^m.axi_rid;

    assign s0.axi_rvalid = rst_n && m.axi_rvalid && !tag_c;
    assign s1.axi_rvalid = rst_n && m.axi_rvalid &&  tag_c;
    assign m.axi_rready  = rst_n && (tag_c ? s1.axi_rready : s0.axi_rready);

    assign s0.axi_rid   = m.axi_rid[HACD_AXI4_ID_W-1:0];
    assign s1.axi_rid   = m.axi_rid[HACD_AXI4_ID_W-1:0];
    assign s0.axi_rdata = m.axi_rdata;
    assign s1.axi_rdata = m.axi_rdata;
    assign s0.axi_rresp = m.axi_rresp;
    assign s1.axi_rresp = m.axi_rresp;
    assign s0.axi_rlast = m.axi_rlast;
    assign s1.axi_rlast = m.axi_rlast;
    assign s0.axi_ruser = m.axi_ruser;
    assign s1.axi_ruser = m.axi_ruser;

    assign r_hs_c     = m.axi_rvalid && m.axi_rready && m.axi_rlast;
    assign rdone_c[0] = r_hs_c && !tag_c;
    assign rdone_c[1] = r_hs_c &&  tag_c;

    // Burst accounting; a coincident accept and final beat cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(HACD_RD_PORTS); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(HACD_RD_PORTS); i++) begin
                if (gnt_c[i] && !rdone_c[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end else if (!gnt_c[i] && rdone_c[i]) begin
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < int'(HACD_RD_PORTS); i++) begin
                assert (!(rdone_c[i] && (cnt_q[i] == '0)));
            end
        end
    end

    assign busy = (state_q == AR_HOLD) || (cnt_q[0] != '0) || (cnt_q[1] != '0);

endmodule
